// File: rtl/intr_req_conditioner.sv
// Interrupt request conditioner: synchronises raw interrupt lines,
// latches them as level or edge requests, masks them and serves config/status over the bus.
module intr_req_conditioner #(
   parameter int NUM_P_CTRLR = 16,
   parameter int ADDR_W      = 3
) (
   input  logic                   pclk,
   input  logic                   prst,
   input  logic [ADDR_W-1:0]      paddr,
   input  logic                   pwrite,
   input  logic                   penable,
   input  logic [NUM_P_CTRLR-1:0] pwdata,
   output logic [NUM_P_CTRLR-1:0] prdata,
   output logic                   pready,
   output logic                   perror,
   input  logic [NUM_P_CTRLR-1:0] irq_raw_i,
   input  logic                   intr_serviced_i,
   input  logic [NUM_P_CTRLR-1:0] intr_to_service_i,
   output logic [NUM_P_CTRLR-1:0] intr_active_o
);

   typedef logic [NUM_P_CTRLR-1:0] vec_t;

   localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_MODE = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_PEND = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_OVR  = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_RAW  = ADDR_W'(4);

   vec_t s1_q, s1_d;
   vec_t s2_q, s2_d;
   vec_t s3_q, s3_d;
   vec_t mask_q, mask_d;
   vec_t mode_q, mode_d;
   vec_t pend_q, pend_d;
   vec_t ovr_q, ovr_d;
   vec_t prdata_q, prdata_d;
   logic pready_q, pready_d;
   logic perror_q, perror_d;

   logic access;
   logic bad;
   logic sel_mask;
   logic sel_mode;
   logic sel_pend;
   logic sel_ovr;
   vec_t rd_val;
   vec_t rise;
   vec_t clr;
   vec_t svc_clr;
   vec_t w1c_pend;
   vec_t w1c_ovr;

   // A transfer is accepted only while no completion pulse is showing,
   // so a held penable cannot hit the register file twice.
   assign access = penable & ~pready_q;

   // Address decode: read mux, register selects and the error condition.
   always_comb begin
      bad      = 1'b1;
      sel_mask = 1'b0;
      sel_mode = 1'b0;
      sel_pend = 1'b0;
      sel_ovr  = 1'b0;
      rd_val   = '0;
      unique case (paddr)
         A_MASK: begin
            bad      = 1'b0;
            sel_mask = 1'b1;
            rd_val   = mask_q;
         end
         A_MODE: begin
            bad      = 1'b0;
            sel_mode = 1'b1;
            rd_val   = mode_q;
         end
         A_PEND: begin
            bad      = 1'b0;
            sel_pend = 1'b1;
            rd_val   = pend_q;
         end
         A_OVR: begin
            bad     = 1'b0;
            sel_ovr = 1'b1;
            rd_val  = ovr_q;
         end
         A_RAW: begin
            bad    = pwrite;
            rd_val = s2_q;
         end
         default: begin
            bad    = 1'b1;
            rd_val = '0;
         end
      endcase
   end

   // Bus side next state: config writes, read capture and the completion pulse.
   always_comb begin
      mask_d   = mask_q;
      mode_d   = mode_q;
      w1c_pend = '0;
      w1c_ovr  = '0;
      prdata_d = '0;
      pready_d = access;
      perror_d = access & bad;
      if (access && pwrite && !bad) begin
         if (sel_mask) mask_d = pwdata;
         if (sel_mode) mode_d = pwdata;
         if (sel_pend) w1c_pend = pwdata;
         if (sel_ovr)  w1c_ovr  = pwdata;
      end
      if (access && !pwrite && !bad) begin
         prdata_d = rd_val;
      end
   end

   // Two-flop synchroniser plus one more stage for rise detection.
   always_comb begin
      s1_d = irq_raw_i;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   assign rise    = s2_q & ~s3_q;
   assign svc_clr = intr_serviced_i ? intr_to_service_i : '0;
   assign clr     = svc_clr | w1c_pend;

   // Pending/overrun update; in edge mode a new rise beats any clear.
   always_comb begin
      pend_d = (mode_q & (rise | (pend_q & ~clr)))
             | (~mode_q & s2_q);
      ovr_d  = (ovr_q & ~w1c_ovr)
             | (mode_q & rise & pend_q & ~clr);
   end

   // State register for all flops.
   always_ff @(posedge pclk) begin
      if (prst) begin
         s1_q     <= '0;
         s2_q     <= '0;
         s3_q     <= '0;
         mask_q   <= '1;
         mode_q   <= '0;
         pend_q   <= '0;
         ovr_q    <= '0;
         prdata_q <= '0;
         pready_q <= 1'b0;
         perror_q <= 1'b0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         s3_q     <= s3_d;
         mask_q   <= mask_d;
         mode_q   <= mode_d;
         pend_q   <= pend_d;
         ovr_q    <= ovr_d;
         prdata_q <= prdata_d;
         pready_q <= pready_d;
         perror_q <= perror_d;
      end
   end

   assign prdata        = prdata_q;
   assign pready        = pready_q;
   assign perror        = perror_q;
   assign intr_active_o = pend_q & mask_q;

endmodule

// File: tb/tb_intr_req_conditioner.sv
// Directed bench for intr_req_conditioner.
// Each task drives one scenario and checks against hand-derived values.
module tb_intr_req_conditioner;

   logic        pclk = 1'b0;
   logic        prst = 1'b1;
   logic [2:0]  paddr = '0;
   logic        pwrite = 1'b0;
   logic        penable = 1'b0;
   logic [15:0] pwdata = '0;
   logic [15:0] prdata;
   logic        pready;
   logic        perror;
   logic [15:0] irq_raw_i = '0;
   logic        intr_serviced_i = 1'b0;
   logic [15:0] intr_to_service_i = '0;
   logic [15:0] intr_active_o;

   int n_checks = 0;
   int n_fail = 0;

   intr_req_conditioner #(.NUM_P_CTRLR(16), .ADDR_W(3)) dut (
      .pclk(pclk),
      .prst(prst),
      .paddr(paddr),
      .pwrite(pwrite),
      .penable(penable),
      .pwdata(pwdata),
      .prdata(prdata),
      .pready(pready),
      .perror(perror),
      .irq_raw_i(irq_raw_i),
      .intr_serviced_i(intr_serviced_i),
      .intr_to_service_i(intr_to_service_i),
      .intr_active_o(intr_active_o)
   );

   always #5 pclk = ~pclk;

   task automatic tick(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic bus(input logic [2:0] a, input logic w,
                      input logic [15:0] d,
                      output logic [15:0] rd, output logic er);
      bit got;
      got = 0;
      paddr = a;
      pwrite = w;
      pwdata = d;
      penable = 1'b1;
      for (int i = 0; i < 8 && !got; i++) begin
         tick(1);
         if (pready === 1'b1) got = 1;
      end
      rd = prdata;
      er = perror;
      penable = 1'b0;
      pwrite = 1'b0;
      n_checks++;
      if (!got) begin
         $display("FAIL bus_timeout addr=%0d pready=%b want 1", a, pready);
         n_fail++;
      end
      tick(1);
      n_checks++;
      if (pready !== 1'b0) begin
         $display("FAIL pready_width addr=%0d pready=%b want 0", a, pready);
         n_fail++;
      end
   endtask

   task automatic pulse(input logic [15:0] v);
      irq_raw_i = v;
      tick(1);
      irq_raw_i = '0;
      tick(3);
   endtask

   task automatic test_reset;
      logic [15:0] rd;
      logic er;
      prst = 1'b1;
      tick(2);
      n_checks++;
      if ({intr_active_o, prdata, pready, perror} !== 34'h0) begin
         $display("FAIL reset_outputs act=%h rd=%h rdy=%b err=%b want 0",
                  intr_active_o, prdata, pready, perror);
         n_fail++;
      end
      prst = 1'b0;
      tick(1);
      bus(3'd0, 1'b0, '0, rd, er);
      n_checks++;
      if (rd !== 16'hFFFF || er !== 1'b0) begin
         $display("FAIL reset_mask got=%h err=%b want FFFF/0", rd, er);
         n_fail++;
      end
      bus(3'd1, 1'b0, '0, rd, er);
      n_checks++;
      if (rd !== 16'h0000) begin
         $display("FAIL reset_mode got=%h want 0000", rd);
         n_fail++;
      end
   endtask

   task automatic test_level;
      irq_raw_i = 16'h00A5;
      tick(2);
      n_checks++;
      if (intr_active_o !== 16'h0000) begin
         $display("FAIL level_early got=%h want 0000", intr_active_o);
         n_fail++;
      end
      tick(1);
      n_checks++;
      if (intr_active_o !== 16'h00A5) begin
         $display("FAIL level_on got=%h want 00A5", intr_active_o);
         n_fail++;
      end
      irq_raw_i = '0;
      tick(3);
      n_checks++;
      if (intr_active_o !== 16'h0000) begin
         $display("FAIL level_off got=%h want 0000", intr_active_o);
         n_fail++;
      end
   endtask

   task automatic test_edge_service;
      logic [15:0] rd;
      logic er;
      bus(3'd1, 1'b1, 16'hFFFF, rd, er);
      pulse(16'h0008);
      n_checks++;
      if (intr_active_o !== 16'h0008) begin
         $display("FAIL edge_set got=%h want 0008", intr_active_o);
         n_fail++;
      end
      tick(3);
      n_checks++;
      if (intr_active_o !== 16'h0008) begin
         $display("FAIL edge_sticky got=%h want 0008", intr_active_o);
         n_fail++;
      end
      intr_serviced_i = 1'b1;
      intr_to_service_i = 16'h0008;
      tick(1);
      intr_serviced_i = 1'b0;
      intr_to_service_i = '0;
      n_checks++;
      if (intr_active_o !== 16'h0000) begin
         $display("FAIL edge_service got=%h want 0000", intr_active_o);
         n_fail++;
      end
      bus(3'd2, 1'b0, '0, rd, er);
      n_checks++;
      if (rd !== 16'h0000) begin
         $display("FAIL edge_pend_rd got=%h want 0000", rd);
         n_fail++;
      end
   endtask

   task automatic test_mask;
      logic [15:0] rd;
      logic er;
      bus(3'd0, 1'b1, 16'hFFFE, rd, er);
      pulse(16'h0001);
      n_checks++;
      if (intr_active_o !== 16'h0000) begin
         $display("FAIL mask_hide got=%h want 0000", intr_active_o);
         n_fail++;
      end
      bus(3'd2, 1'b0, '0, rd, er);
      n_checks++;
      if (rd !== 16'h0001) begin
         $display("FAIL mask_pend_rd got=%h want 0001", rd);
         n_fail++;
      end
      bus(3'd0, 1'b1, 16'hFFFF, rd, er);
      n_checks++;
      if (intr_active_o !== 16'h0001) begin
         $display("FAIL mask_unmask got=%h want 0001", intr_active_o);
         n_fail++;
      end
      bus(3'd2, 1'b1, 16'h0001, rd, er);
      n_checks++;
      if (intr_active_o !== 16'h0000) begin
         $display("FAIL pend_w1c got=%h want 0000", intr_active_o);
         n_fail++;
      end
   endtask

   task automatic test_overrun;
      logic [15:0] rd;
      logic er;
      pulse(16'h0020);
      n_checks++;
      if (intr_active_o !== 16'h0020) begin
         $display("FAIL ovr_first got=%h want 0020", intr_active_o);
         n_fail++;
      end
      pulse(16'h0020);
      bus(3'd3, 1'b0, '0, rd, er);
      n_checks++;
      if (rd !== 16'h0020) begin
         $display("FAIL ovr_set got=%h want 0020", rd);
         n_fail++;
      end
      bus(3'd3, 1'b1, 16'h0020, rd, er);
      bus(3'd3, 1'b0, '0, rd, er);
      n_checks++;
      if (rd !== 16'h0000) begin
         $display("FAIL ovr_w1c got=%h want 0000", rd);
         n_fail++;
      end
      irq_raw_i = 16'h0020;
      tick(1);
      irq_raw_i = '0;
      tick(1);
      intr_serviced_i = 1'b1;
      intr_to_service_i = 16'h0020;
      tick(1);
      intr_serviced_i = 1'b0;
      intr_to_service_i = '0;
      n_checks++;
      if (intr_active_o !== 16'h0020) begin
         $display("FAIL set_beats_clr got=%h want 0020", intr_active_o);
         n_fail++;
      end
      bus(3'd3, 1'b0, '0, rd, er);
      n_checks++;
      if (rd !== 16'h0000) begin
         $display("FAIL ovr_on_clr got=%h want 0000", rd);
         n_fail++;
      end
   endtask

   task automatic test_bus;
      logic [15:0] rd;
      logic er;
      irq_raw_i = 16'h1200;
      tick(3);
      bus(3'd4, 1'b0, '0, rd, er);
      n_checks++;
      if (rd !== 16'h1200 || er !== 1'b0) begin
         $display("FAIL raw_rd got=%h err=%b want 1200/0", rd, er);
         n_fail++;
      end
      bus(3'd4, 1'b1, 16'hFFFF, rd, er);
      n_checks++;
      if (er !== 1'b1) begin
         $display("FAIL raw_wr_err got=%b want 1", er);
         n_fail++;
      end
      bus(3'd4, 1'b0, '0, rd, er);
      n_checks++;
      if (rd !== 16'h1200) begin
         $display("FAIL raw_unchanged got=%h want 1200", rd);
         n_fail++;
      end
      bus(3'd6, 1'b0, '0, rd, er);
      n_checks++;
      if (rd !== 16'h0000 || er !== 1'b1) begin
         $display("FAIL rsvd_rd got=%h err=%b want 0000/1", rd, er);
         n_fail++;
      end
      bus(3'd0, 1'b0, '0, rd, er);
      n_checks++;
      if (rd !== 16'hFFFF || er !== 1'b0) begin
         $display("FAIL mask_rd got=%h err=%b want FFFF/0", rd, er);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] rd;
      logic er;
      irq_raw_i = 16'hFFFF;
      tick(4);
      bus(3'd2, 1'b0, '0, rd, er);
      n_checks++;
      if (rd !== 16'hFFFF) begin
         $display("FAIL pend_all got=%h want FFFF", rd);
         n_fail++;
      end
      paddr = 3'd0;
      pwrite = 1'b1;
      pwdata = 16'h0000;
      penable = 1'b1;
      prst = 1'b1;
      tick(1);
      n_checks++;
      if (pready !== 1'b0) begin
         $display("FAIL rst_pready got=%b want 0", pready);
         n_fail++;
      end
      penable = 1'b0;
      pwrite = 1'b0;
      irq_raw_i = '0;
      tick(1);
      prst = 1'b0;
      tick(1);
      bus(3'd2, 1'b0, '0, rd, er);
      n_checks++;
      if (rd !== 16'h0000) begin
         $display("FAIL rst_pend got=%h want 0000", rd);
         n_fail++;
      end
      bus(3'd1, 1'b0, '0, rd, er);
      n_checks++;
      if (rd !== 16'h0000) begin
         $display("FAIL rst_mode got=%h want 0000", rd);
         n_fail++;
      end
      bus(3'd0, 1'b0, '0, rd, er);
      n_checks++;
      if (rd !== 16'hFFFF) begin
         $display("FAIL rst_mask got=%h want FFFF", rd);
         n_fail++;
      end
   endtask

   initial begin
      @(posedge pclk);
      #1;
      test_reset();
      test_level();
      test_edge_service();
      test_mask();
      test_overrun();
      test_bus();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/intr_req_conditioner.md
Name: intr_req_conditioner

Overview:
- Upstream front-end for the priority interrupt controller.
- Takes asynchronous peripheral interrupt lines and synchronises them.
- Per source, conditions each line as level- or edge-triggered with a sticky pending latch, applies a mask, and drives the controller's active-request vector.
- Pending bits clear on the controller's service handshake. Configuration and status are reached through the same APB-style bus used by the controller.

Parameters:
NUM_P_CTRLR, 16, number of interrupt sources (bus data width equals NUM_P_CTRLR)
ADDR_W, 3, register address width (fixed register map below)

Ports:
pclk  input  1  clock; all logic on rising edge
prst  input  1  reset, synchronous, active-high
paddr  input  ADDR_W  register address
pwrite  input  1  1=write, 0=read
penable  input  1  transfer request, held by master until pready
pwdata  input  NUM_P_CTRLR  write data
prdata  output  NUM_P_CTRLR  read data, valid while pready=1
pready  output  1  one-cycle transfer-complete pulse
perror  output  1  error flag, valid while pready=1
irq_raw_i  input  NUM_P_CTRLR  asynchronous peripheral interrupt lines
intr_serviced_i  input  1  controller/processor service-complete pulse
intr_to_service_i  input  NUM_P_CTRLR  one-hot source being serviced
intr_active_o  output  NUM_P_CTRLR  conditioned request vector to the controller

Behaviour:
- Clock and reset: one clock, pclk. prst is synchronous and active-high.
- Reset state:
  - Synchroniser stages, prev-sample, PENDING and OVERRUN registers clear to 0.
  - MASK resets to all 1s; MODE resets to all 0s (all sources level-triggered).
  - pready, perror and prdata reset to 0.
  - With these reset values the block is a transparent, synchronised pass-through.
- Register map:
  - 0 MASK: RW.
  - 1 MODE: RW; 1=edge, 0=level.
  - 2 PENDING: read returns pending; write is write-1-to-clear.
  - 3 OVERRUN: read returns overrun; write is write-1-to-clear.
  - 4 RAW: read-only, returns the synchronised lines.
  - 5-7: reserved.
- Bus transfer:
  - An access occurs on an edge where penable=1 and pready=0. The write takes effect at that edge, and prdata is captured at that edge.
  - pready=1 for exactly the following cycle, then it is forced low, so each transfer takes 2 cycles.
  - A held penable cannot double-access.
  - perror=1 with pready for a write to address 4, or any access to addresses 5-7. Such writes have no effect and reads return 0.
- Synchroniser: two flops per line (s1, s2) plus s3, the previous s2 value.
  - rise = s2 & ~s3.
- Pending update, per bit per edge:
  - Level mode: pending <= s2. Service and W1C clears are ignored; overrun is never set.
  - Edge mode: pending <= rise | (pending & ~clr), where clr = (intr_serviced_i ? intr_to_service_i : 0) | W1C data. A set wins over a clear in the same cycle.
  - OVERRUN bit sets when rise=1 and pending=1 and clr=0 for that bit. It is sticky until W1C.
  - A non-one-hot intr_to_service_i clears every indicated bit.
- Output: intr_active_o = pending & MASK, purely from registers.
  - A masked source still latches pending, and it appears on the output when unmasked.
- Latency: irq_raw_i first sampled high at edge k gives intr_active_o=1 after edge k+2, in both modes.
- Mode change:
  - Edge to level: pending tracks s2 from the next edge.
  - Level to edge: pending keeps its current value; only new rises set it.
- Reset asserted mid-transfer: pready=0 the next cycle. The master must re-issue the transfer.

Test Plan:
1. After reset, all modes level, mask all 1s: irq_raw_i=16'h00A5 held -> intr_active_o=16'h00A5 three edges later. irq_raw_i=0 -> output 0 three edges later.
2. Write MODE=16'hFFFF. Pulse irq_raw_i[3] for 1 cycle -> intr_active_o[3]=1 and stays 1. intr_serviced_i with intr_to_service_i=16'h0008 -> bit 3 clears the next edge. PENDING reads 0.
3. Edge mode, MASK=16'hFFFE: pulse bit 0 -> intr_active_o=0 and PENDING read=16'h0001. Write MASK=16'hFFFF -> intr_active_o=16'h0001.
4. Edge mode, bit 5 pending: second rise on bit 5 with no clear -> OVERRUN=16'h0020. Write 16'h0020 to addr 3 -> OVERRUN reads 0. A rise coinciding with a service clear of bit 5 -> pending stays 1, no overrun.
5. Bus: write to addr 4 -> pready pulse with perror=1, RAW unchanged. Read addr 6 -> prdata=0, perror=1. Read MASK after reset -> 16'hFFFF, perror=0, pready high exactly one cycle.
6. Assert prst while PENDING=16'hFFFF and a write is in flight -> PENDING=0, MODE=0, MASK=16'hFFFF, pready=0 the next cycle.
